// File: rtl/sprite_scheduler_if.sv
// rtl/sprite_scheduler_if.sv - command handshake bundle for sprite_scheduler
//
// Ports (modports):
//   master : drives cmd_valid, cmd_op; observes cmd_ready
//   slave  : observes cmd_valid, cmd_op; drives cmd_ready
//   cmd_op encoding: 0=RUN, 1=PAUSE, 2=STEP, 3=HOME
interface sprite_scheduler_if;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd_op, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - frame-locked sprite position sweep with RUN/PAUSE/STEP/HOME control
//
// Ports:
//   clk_pix    : pixel clock, the only clock
//   rst_pix    : asynchronous active-high reset
//   frame      : single-cycle start-of-blanking pulse
//   cmd        : command handshake (sprite_scheduler_if.slave)
//   sprx, spry : signed sprite position, updated only in the cycle after frame
//   running    : high in RUN state
//   step_pulse : one-cycle pulse on every position update (steps and HOME)
//   wrap       : one-cycle pulse when the sweep returns to (0,0) from the last tile
//
// Optional feature: define SPRITE_SCHED_SERP_EN for serpentine traversal
// (odd rows run right-to-left). Default build is raster order only.
module sprite_scheduler #(
   parameter int CORDW     = 16,
   parameter int H_RES     = 480,
   parameter int V_RES     = 272,
   parameter int TILE_W    = 64,
   parameter int TILE_H    = 64,
   parameter int FRAME_DIV = 1
) (
   input  logic                    clk_pix,
   input  logic                    rst_pix,
   input  logic                    frame,
   sprite_scheduler_if.slave       cmd,
   output logic signed [CORDW-1:0] sprx,
   output logic signed [CORDW-1:0] spry,
   output logic                    running,
   output logic                    step_pulse,
   output logic                    wrap
);
   typedef enum logic [1:0] {ST_PAUSED = 2'd0, ST_RUN = 2'd1, ST_PEND = 2'd2} state_t;

   localparam logic [1:0] OP_RUN   = 2'd0;
   localparam logic [1:0] OP_PAUSE = 2'd1;
   localparam logic [1:0] OP_HOME  = 2'd3;

   // One extra bit so that x+TILE_W and x-TILE_W never overflow before the compare.
   localparam int AW = CORDW + 1;
   localparam logic signed [AW-1:0] TW    = AW'(TILE_W);
   localparam logic signed [AW-1:0] TH    = AW'(TILE_H);
   localparam logic signed [AW-1:0] X_LIM = AW'(H_RES - TILE_W);
   localparam logic signed [AW-1:0] Y_LIM = AW'(V_RES - TILE_H);
   localparam logic [7:0]           DIV_LAST = 8'(FRAME_DIV - 1);
`ifdef SPRITE_SCHED_SERP_EN
   localparam logic [CORDW-1:0]     X_LAST = CORDW'(((H_RES - TILE_W) / TILE_W) * TILE_W);
`endif

   state_t                  state_q, state_d;
   logic                    pend_home_q, pend_home_d;   // pending op: 1=HOME, 0=STEP
   logic                    prior_run_q, prior_run_d;   // state to return to after PEND
   logic [7:0]              div_q, div_d;
   logic signed [CORDW-1:0] sprx_q, sprx_d;
   logic signed [CORDW-1:0] spry_q, spry_d;
   logic                    step_q, step_d;
   logic                    wrap_q, wrap_d;
`ifdef SPRITE_SCHED_SERP_EN
   logic                    dir_q, dir_d;               // 1 = right-to-left row
`endif

   logic signed [AW-1:0]    x_ext, y_ext, nx, ny;
   logic [CORDW-1:0]        new_x, new_y;
   logic                    row_adv, wrap_now, accept, do_step, do_home;

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         state_q     <= ST_PAUSED;
         pend_home_q <= 1'b0;
         prior_run_q <= 1'b0;
         div_q       <= '0;
         sprx_q      <= '0;
         spry_q      <= '0;
         step_q      <= 1'b0;
         wrap_q      <= 1'b0;
`ifdef SPRITE_SCHED_SERP_EN
         dir_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pend_home_q <= pend_home_d;
         prior_run_q <= prior_run_d;
         div_q       <= div_d;
         sprx_q      <= sprx_d;
         spry_q      <= spry_d;
         step_q      <= step_d;
         wrap_q      <= wrap_d;
`ifdef SPRITE_SCHED_SERP_EN
         dir_q       <= dir_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      pend_home_d = pend_home_q;
      prior_run_d = prior_run_q;
      div_d       = div_q;
      sprx_d      = sprx_q;
      spry_d      = spry_q;
      step_d      = 1'b0;
      wrap_d      = 1'b0;
      do_step     = 1'b0;
      do_home     = 1'b0;
      row_adv     = 1'b0;
      wrap_now    = 1'b0;
      x_ext       = {sprx_q[CORDW-1], sprx_q};
      y_ext       = {spry_q[CORDW-1], spry_q};
      nx          = x_ext + TW;
      ny          = y_ext + TH;
      new_x       = nx[CORDW-1:0];
      new_y       = spry_q;
      accept      = cmd.cmd_valid && (state_q != ST_PEND);

      // Frame processing always uses the pre-command state; a command
      // accepted in the same cycle only redirects the next state.
      if (frame) begin
         case (state_q)
            ST_RUN: begin
               if (div_q == DIV_LAST) begin
                  div_d   = '0;
                  do_step = 1'b1;
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
            ST_PEND: begin
               do_home = pend_home_q;
               do_step = !pend_home_q;
               state_d = prior_run_q ? ST_RUN : ST_PAUSED;
            end
            default: ;
         endcase
      end

      if (accept) begin
         case (cmd.cmd_op)
            OP_RUN:   state_d = ST_RUN;
            OP_PAUSE: state_d = ST_PAUSED;
            default: begin
               state_d     = ST_PEND;
               pend_home_d = (cmd.cmd_op == OP_HOME);
               prior_run_d = (state_q == ST_RUN);
            end
         endcase
      end

      // Next tile position, consumed only when a step executes.
`ifdef SPRITE_SCHED_SERP_EN
      dir_d = dir_q;
      if (dir_q) begin
         nx = x_ext - TW;
         if (nx[AW-1]) begin
            row_adv = 1'b1;
            new_x   = '0;
         end else begin
            new_x = nx[CORDW-1:0];
         end
      end else if (nx > X_LIM) begin
         row_adv = 1'b1;
         new_x   = X_LAST;
      end
`else
      if (nx > X_LIM) begin
         row_adv = 1'b1;
         new_x   = '0;
      end
`endif
      if (row_adv) begin
         if (ny > Y_LIM) begin
            new_y    = '0;
            new_x    = '0;
            wrap_now = 1'b1;
         end else begin
            new_y = ny[CORDW-1:0];
         end
      end

      if (do_home) begin
         sprx_d = '0;
         spry_d = '0;
         div_d  = '0;
         step_d = 1'b1;
`ifdef SPRITE_SCHED_SERP_EN
         dir_d  = 1'b0;
`endif
      end else if (do_step) begin
         sprx_d = new_x;
         spry_d = new_y;
         step_d = 1'b1;
         wrap_d = wrap_now;
`ifdef SPRITE_SCHED_SERP_EN
         if (wrap_now)     dir_d = 1'b0;
         else if (row_adv) dir_d = ~dir_q;
`endif
      end
   end

   assign cmd.cmd_ready = (state_q != ST_PEND);
   assign running       = (state_q == ST_RUN);
   assign sprx          = sprx_q;
   assign spry          = spry_q;
   assign step_pulse    = step_q;
   assign wrap          = wrap_q;
endmodule

// File: doc/sprite_scheduler.md
SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 The block SHALL have parameter CORDW, default 16: signed coordinate width in bits.
REQ-002 The block SHALL have parameter H_RES, default 480: active horizontal pixels.
REQ-003 The block SHALL have parameter V_RES, default 272: active vertical lines.
REQ-004 The block SHALL have parameter TILE_W, default 64: horizontal step in pixels (sprite width times scale).
REQ-005 The block SHALL have parameter TILE_H, default 64: vertical step in lines.
REQ-006 The block SHALL have parameter FRAME_DIV, default 1: frames per automatic step, range 1..255.
REQ-007 The block SHALL have port clk_pix, input, 1 bit: pixel clock; the only clock.
REQ-008 The block SHALL have port rst_pix, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The block SHALL have port frame, input, 1 bit: single-cycle start-of-blanking pulse from the display timing block.
REQ-010 The block SHALL have port cmd_valid, input, 1 bit: command request.
REQ-011 The block SHALL have port cmd_op, input, 2 bits: 0=RUN, 1=PAUSE, 2=STEP, 3=HOME.
REQ-012 The block SHALL have port cmd_ready, output, 1 bit: command accept.
REQ-013 The block SHALL have port sprx, output, CORDW bits signed: sprite x position.
REQ-014 The block SHALL have port spry, output, CORDW bits signed: sprite y position.
REQ-015 The block SHALL have port running, output, 1 bit: high in RUN state.
REQ-016 The block SHALL have port step_pulse, output, 1 bit: one-cycle pulse on every position update.
REQ-017 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when the sweep returns to (0,0) from the last tile.

Function
REQ-018 A command SHALL be accepted in a cycle only when cmd_valid and cmd_ready are both high; cmd_op is sampled only in that cycle.
REQ-019 States SHALL be PAUSED, RUN and PEND; cmd_ready SHALL be high in PAUSED and RUN and low in PEND.
REQ-020 In PAUSED or RUN, RUN SHALL go to RUN, PAUSE SHALL go to PAUSED, and STEP or HOME SHALL go to PEND, recording the op and the prior state.
REQ-021 sprx and spry SHALL change only in the cycle after a frame pulse, so that positions are stable through active video.
REQ-022 In RUN, a frame pulse SHALL increment a divider; when the divider equals FRAME_DIV-1 it SHALL clear and one step SHALL occur.
REQ-023 In PEND, a frame pulse SHALL execute the pending op (STEP: one step; HOME: sprx=spry=0, divider cleared, no wrap pulse) and SHALL return to the recorded prior state.
REQ-024 A step SHALL be: nx=sprx+TILE_W; if nx>H_RES-TILE_W then sprx=0 and a row advance occurs, else sprx=nx.
REQ-025 A row advance SHALL be: ny=spry+TILE_H; if ny>V_RES-TILE_H then spry=0 and wrap pulses, else spry=ny.
REQ-026 With default parameters, the sweep SHALL be 7 columns (x=0..384) by 4 rows (y=0..192), with a wrap every 28 steps.
REQ-027 If a command is accepted in the same cycle as a frame pulse, the frame SHALL be processed with the pre-command state, and the command SHALL take effect from the next cycle.
REQ-028 step_pulse SHALL assert for every executed STEP and automatic step, and for HOME.
REQ-029 Arithmetic SHALL be in CORDW+1 bits to prevent overflow on the compares.

Reset
REQ-030 Asserting rst_pix SHALL immediately set state=PAUSED, sprx=0, spry=0, divider=0, step_pulse=0, wrap=0, running=0 and cmd_ready=1, including while in PEND; any pending op SHALL be discarded.
REQ-031 The first frame pulse after reset release SHALL cause no step.

Configuration
REQ-032 When SPRITE_SCHED_SERP_EN is defined, a direction bit SHALL be present, with odd rows traversed right-to-left: on those rows a step SHALL subtract TILE_W, and when the result is below 0 a row advance SHALL occur with sprx set to the last column (384 by default).
REQ-033 When SPRITE_SCHED_SERP_EN is defined, HOME, wrap and reset SHALL clear the direction bit.
REQ-034 When SPRITE_SCHED_SERP_EN is undefined, the sweep SHALL be raster order only, with no direction logic.

Verification
REQ-035 Reset, then 3 frame pulses -> sprx=spry=0, no step_pulse, running=0.
REQ-036 RUN command with FRAME_DIV=1, then 7 frames -> sprx sequence 64,128,...,384,0 and spry=64 after the 7th frame; without SPRITE_SCHED_SERP_EN.
REQ-037 RUN for 28 frames -> wrap pulses exactly once, on the 28th frame, with (0,0) following.
REQ-038 PAUSED then STEP -> cmd_ready=0 until the next frame, sprx 0->64, state returns to PAUSED, and a second cmd_valid is held off while in PEND.
REQ-039 RUN with FRAME_DIV=3, 6 frames, then HOME accepted on the same cycle as a frame pulse -> steps on frames 3 and 6, that frame stepped normally, and position (0,0) on the following frame with state RUN.
REQ-040 With SPRITE_SCHED_SERP_EN defined, 14 steps -> row 1 x sequence 384,320,...,0, with spry=128 and sprx=0 after step 14.
